// File: rtl/mfm_enc_if.sv
// mfm_enc_if: byte handshake and write-path signals between the FDC main FSM
// (master) and the MFM write encoder (slave).
//   iSTART      write enable; low clears the encoder to idle
//   iWR         one-cycle byte write strobe
//   iBYTE       byte to write, sampled with iWR
//   iMARK       byte is an A1 sync mark, sampled with iWR
//   oREADY      holding register empty (DRQ source)
//   oWDATA      MFM write pulse train
//   oWG         write gate
//   oLOST       one-cycle underrun pulse
//   oBYTE_DONE  one-cycle pulse when the last cell of a byte completes
interface mfm_enc_if;
  logic       iSTART;
  logic       iWR;
  logic [7:0] iBYTE;
  logic       iMARK;
  logic       oREADY;
  logic       oWDATA;
  logic       oWG;
  logic       oLOST;
  logic       oBYTE_DONE;

  modport master (
    output iSTART, iWR, iBYTE, iMARK,
    input  oREADY, oWDATA, oWG, oLOST, oBYTE_DONE
  );

  modport slave (
    input  iSTART, iWR, iBYTE, iMARK,
    output oREADY, oWDATA, oWG, oLOST, oBYTE_DONE
  );
endinterface

// File: rtl/mfm_enc.sv
// mfm_enc: MFM write-path encoder. Bytes enter a one-deep holding register,
// are serialised MSB-first into 16 MFM cells (clock cell, data cell per bit)
// and emitted as fixed-width pulses on oWDATA. Supports A1 marks with a
// missing clock and flags underruns by sending a 0x00 filler byte.
//   iCLK      system clock, rising edge
//   iRESET_N  asynchronous active-low reset
//   bus       mfm_enc_if.slave handshake and write outputs
module mfm_enc #(
  parameter int unsigned CELL_CLKS  = 56,  // clocks per MFM cell, 8..255
  parameter int unsigned PULSE_CLKS = 8    // write pulse width, < CELL_CLKS
) (
  input  logic      iCLK,
  input  logic      iRESET_N,
  mfm_enc_if.slave  bus
);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StRun  = 1'b1;

  localparam logic [7:0] CellLast  = 8'(CELL_CLKS - 1);
  localparam logic [7:0] PulseClks = 8'(PULSE_CLKS);

  logic [0:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] idx_q, idx_d;
  logic [7:0] sr_q, sr_d;
  logic       mark_q, mark_d;
  logic       prev_q, prev_d;
  logic [7:0] hr_q, hr_d;
  logic       hr_mark_q, hr_mark_d;
  logic       hr_full_q, hr_full_d;
  logic       lost_q, lost_d;
  logic       done_q, done_d;

  logic data_bit, cell_val, cell_end, byte_end, run;

  assign run      = (state_q == StRun);
  // idx_q[3:1] selects the bit, MSB first
  assign data_bit = sr_q[3'd7 - idx_q[3:1]];
  // Cell index 10 is the clock cell of bit 5 from the MSB; A1 marks drop it.
  assign cell_val = idx_q[0] ? data_bit
                             : (~(prev_q | data_bit) & ~(mark_q && (idx_q == 4'd10)));
  assign cell_end = run && (cnt_q == CellLast);
  assign byte_end = cell_end && (idx_q == 4'd15);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    sr_d      = sr_q;
    mark_d    = mark_q;
    prev_d    = prev_q;
    hr_d      = hr_q;
    hr_mark_d = hr_mark_q;
    hr_full_d = hr_full_q;
    lost_d    = 1'b0;
    done_d    = 1'b0;

    if (!bus.iSTART) begin
      state_d   = StIdle;
      cnt_d     = '0;
      idx_d     = '0;
      prev_d    = 1'b0;
      hr_full_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          prev_d = 1'b0;
          if (hr_full_q) begin
            sr_d      = hr_q;
            mark_d    = hr_mark_q;
            hr_full_d = 1'b0;
            state_d   = StRun;
            cnt_d     = '0;
            idx_d     = '0;
          end
        end
        StRun: begin
          if (cell_end) begin
            cnt_d = '0;
            idx_d = idx_q + 4'd1;  // wraps 15 -> 0 into the next byte
            if (idx_q[0]) prev_d = data_bit;
            if (byte_end) begin
              done_d = 1'b1;
              if (hr_full_q) begin
                sr_d      = hr_q;
                mark_d    = hr_mark_q;
                hr_full_d = 1'b0;
              end else begin
                sr_d   = 8'h00;
                mark_d = 1'b0;
                lost_d = 1'b1;
              end
            end
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        default: state_d = StIdle;
      endcase

      // Loads only into an empty HR, so a write in the same cycle as a
      // boundary transfer lands after the transfer (filler or not).
      if (bus.iWR && !hr_full_q) begin
        hr_d      = bus.iBYTE;
        hr_mark_d = bus.iMARK;
        hr_full_d = 1'b1;
      end
    end
  end

  always_ff @(posedge iCLK or negedge iRESET_N) begin
    if (!iRESET_N) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      idx_q     <= '0;
      sr_q      <= '0;
      mark_q    <= 1'b0;
      prev_q    <= 1'b0;
      hr_q      <= '0;
      hr_mark_q <= 1'b0;
      hr_full_q <= 1'b0;
      lost_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      sr_q      <= sr_d;
      mark_q    <= mark_d;
      prev_q    <= prev_d;
      hr_q      <= hr_d;
      hr_mark_q <= hr_mark_d;
      hr_full_q <= hr_full_d;
      lost_q    <= lost_d;
      done_q    <= done_d;
    end
  end

  assign bus.oREADY     = ~hr_full_q;
  assign bus.oWG        = run;
  assign bus.oWDATA     = run && cell_val && (cnt_q < PulseClks);
  assign bus.oLOST      = lost_q;
  assign bus.oBYTE_DONE = done_q;

endmodule

// File: tb/tb_mfm_enc.sv
module tb_mfm_enc;
  localparam int CELL  = 56;
  localparam int PULSE = 8;
  localparam int BYTE_CLKS = 16 * CELL;

  typedef struct packed {
    logic [15:0] word;
    logic        filler;
  } sb_t;

  typedef struct packed {
    logic [7:0]  b;
    logic        m;
    logic [15:0] w;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  sb_t  sb_q[$];
  vec_t tbl[6];

  always #5 clk = ~clk;

  mfm_enc_if bus ();

  mfm_enc #(
    .CELL_CLKS (CELL),
    .PULSE_CLKS(PULSE)
  ) dut (
    .iCLK    (clk),
    .iRESET_N(rst_n),
    .bus     (bus)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout expected event", name);
  endtask

  // Called at a negedge; returns at the negedge after the strobe.
  task automatic wr_byte(input logic [7:0] b, input logic m, input logic [15:0] w);
    int n = 0;
    while (!bus.oREADY && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (!bus.oREADY) fail_now("wr_ready");
    else begin
      bus.iWR   = 1'b1;
      bus.iBYTE = b;
      bus.iMARK = m;
      sb_q.push_back('{word: w, filler: 1'b0});
      @(negedge clk);
      bus.iWR = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) fail_now("drain");
  endtask

  // Monitor: rebuilds each 16-cell word from oWDATA, checks pulse shape,
  // byte boundary pulses, and compares against the scoreboard.
  int          pos = 0;
  int          mc, mcell;
  logic [15:0] word;
  logic        bitv, shape_bad, stray, exp_lost;
  sb_t         e;

  always @(negedge clk) begin
    if (!bus.oWG) begin
      pos = 0;
    end else begin
      mc    = pos % CELL;
      mcell = (pos / CELL) % 16;
      if (mc == 0 && mcell == 0) begin
        word      = '0;
        shape_bad = 1'b0;
        stray     = 1'b0;
        if (pos != 0) begin
          exp_lost = (sb_q.size() == 0) ? 1'b1 : sb_q[0].filler;
          check("byte_done_pulse", 16'(bus.oBYTE_DONE), 16'd1);
          check("lost_pulse", 16'(bus.oLOST), 16'(exp_lost));
        end else if (bus.oBYTE_DONE || bus.oLOST) stray = 1'b1;
      end else if (bus.oBYTE_DONE || bus.oLOST) stray = 1'b1;
      if (mc == 0) begin
        bitv = bus.oWDATA;
        word = {word[14:0], bus.oWDATA};
      end
      if (bus.oWDATA !== ((mc < PULSE) ? bitv : 1'b0)) shape_bad = 1'b1;
      if (mc == CELL - 1 && mcell == 15) begin
        if (sb_q.size() == 0) fail_now("unexpected_byte");
        else begin
          e = sb_q.pop_front();
          check("cell_word", word, e.word);
          check("pulse_shape", 16'(shape_bad), 16'd0);
          check("no_stray_pulse", 16'(stray), 16'd0);
        end
      end
      pos++;
    end
  end

  initial begin
    tbl[0] = '{b: 8'h4E, m: 1'b0, w: 16'h9254};
    tbl[1] = '{b: 8'h00, m: 1'b0, w: 16'hAAAA};
    tbl[2] = '{b: 8'h00, m: 1'b0, w: 16'hAAAA};
    tbl[3] = '{b: 8'hA1, m: 1'b1, w: 16'h4489};
    tbl[4] = '{b: 8'hA1, m: 1'b0, w: 16'h44A9};
    tbl[5] = '{b: 8'hFF, m: 1'b0, w: 16'h5555};

    bus.iSTART = 1'b0;
    bus.iWR    = 1'b0;
    bus.iBYTE  = '0;
    bus.iMARK  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", 16'(bus.oREADY), 16'd1);
    check("rst_wg", 16'(bus.oWG), 16'd0);
    check("rst_wdata", 16'(bus.oWDATA), 16'd0);
    check("rst_lost", 16'(bus.oLOST), 16'd0);
    check("rst_done", 16'(bus.oBYTE_DONE), 16'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Back-to-back table bytes, then two underrun fillers.
    bus.iSTART = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      wr_byte(tbl[i].b, tbl[i].m, tbl[i].w);
      if (i == 0) begin
        check("ready_drop", 16'(bus.oREADY), 16'd0);
        check("wg_before_load", 16'(bus.oWG), 16'd0);
        @(negedge clk);
        check("ready_rise", 16'(bus.oREADY), 16'd1);
        check("wg_run", 16'(bus.oWG), 16'd1);
        check("first_pulse", 16'(bus.oWDATA), 16'd1);
      end
      if (i == 1) begin
        check("hr_full", 16'(bus.oREADY), 16'd0);
        bus.iWR   = 1'b1;  // must be ignored: HR full
        bus.iBYTE = 8'h12;
        bus.iMARK = 1'b1;
        @(negedge clk);
        bus.iWR = 1'b0;
      end
    end
    sb_q.push_back('{word: 16'h2AAA, filler: 1'b1});
    sb_q.push_back('{word: 16'hAAAA, filler: 1'b1});
    wait_drain();
    check("wg_underrun", 16'(bus.oWG), 16'd1);
    bus.iSTART = 1'b0;
    @(negedge clk);
    check("stop_wg", 16'(bus.oWG), 16'd0);

    // Write in the exact cycle of an empty-HR boundary transfer.
    bus.iSTART = 1'b1;
    @(negedge clk);
    wr_byte(8'h4E, 1'b0, 16'h9254);
    @(negedge clk);
    check("bnd_wg", 16'(bus.oWG), 16'd1);
    repeat (BYTE_CLKS - 1) @(negedge clk);
    check("bnd_ready", 16'(bus.oREADY), 16'd1);
    bus.iWR   = 1'b1;
    bus.iBYTE = 8'hC3;
    bus.iMARK = 1'b0;
    sb_q.push_back('{word: 16'hAAAA, filler: 1'b1});
    sb_q.push_back('{word: 16'h52A5, filler: 1'b0});
    @(negedge clk);
    bus.iWR = 1'b0;
    check("bnd_captured", 16'(bus.oREADY), 16'd0);
    sb_q.push_back('{word: 16'h2AAA, filler: 1'b1});
    wait_drain();
    bus.iSTART = 1'b0;
    @(negedge clk);

    // iSTART abort mid-pulse at cell 7 of 0xFF, with HR full.
    for (int k = 0; k < 2; k++) begin
      bus.iSTART = 1'b1;
      @(negedge clk);
      wr_byte(8'hFF, 1'b0, 16'h5555);
      @(negedge clk);
      bus.iWR   = 1'b1;
      bus.iBYTE = 8'h4E;
      bus.iMARK = 1'b0;
      @(negedge clk);
      bus.iWR = 1'b0;
      repeat (7 * CELL + 3 - 1) @(negedge clk);
      check("abort_mid_pulse", 16'(bus.oWDATA), 16'd1);
      check("abort_hr_full", 16'(bus.oREADY), 16'd0);
      if (k == 0) begin
        bus.iSTART = 1'b0;
        @(negedge clk);
      end else begin
        rst_n = 1'b0;
        #1;
      end
      check("abort_wdata", 16'(bus.oWDATA), 16'd0);
      check("abort_wg", 16'(bus.oWG), 16'd0);
      check("abort_ready", 16'(bus.oREADY), 16'd1);
      @(negedge clk);
      rst_n = 1'b1;
      sb_q.delete();
      bus.iSTART = 1'b1;
      @(negedge clk);
      wr_byte(8'h4E, 1'b0, 16'h9254);
      wait_drain();
      bus.iSTART = 1'b0;
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mfm_enc.md
Name: mfm_enc

Overview:
- MFM write-path encoder for the WD1793-compatible FDC core.
- Accepts bytes from the controller main FSM over a one-deep holding register.
- Serialises each byte MSB-first into 16 MFM cells (clock cell, then data cell, per bit) and emits fixed-width write pulses on oWDATA.
- Supports A1 sync marks with a missing clock, and reports data-lost underruns.

Parameters:
CELL_CLKS, 56, iCLK cycles per MFM cell (2 us DD cell at 28 MHz); legal range 8..255.
PULSE_CLKS, 8, width in iCLK cycles of each oWDATA pulse; must be less than CELL_CLKS.

Ports:
iCLK  in  1  system clock; all logic on rising edge.
iRESET_N  in  1  asynchronous active-low reset.
iSTART  in  1  write enable from main FSM; low = synchronous clear to IDLE.
iWR  in  1  one-cycle byte write strobe into the holding register.
iBYTE  in  8  byte to write, sampled with iWR.
iMARK  in  1  sampled with iWR; byte is an A1 mark (suppress clock cell of data bit position 5).
oREADY  out  1  holding register empty (DRQ source).
oWDATA  out  1  MFM write pulse train.
oWG  out  1  write gate, high while in RUN.
oLOST  out  1  one-cycle pulse on underrun.
oBYTE_DONE  out  1  one-cycle pulse when the last cell of a byte completes.

Behaviour:
- Reset (iRESET_N=0, asynchronous):
  - oWDATA=0, oWG=0, oLOST=0, oBYTE_DONE=0, oREADY=1.
  - Holding register empty; prev_data=0; state IDLE; counters 0.
- iSTART=0 (synchronous, takes priority over everything except reset): same values as reset.
  - This includes abort mid-byte: the current pulse is truncated and the holding register is cleared.
- Holding register (HR):
  - iWR with oREADY=1 loads {iMARK, iBYTE}; oREADY falls the next cycle.
  - iWR with oREADY=0 is ignored; the HR contents are unchanged.
- States:
  - IDLE: oWG=0. When iSTART=1 and HR is full, move HR into the shift register (SR). The HR then empties and oREADY rises the next cycle. Go to RUN with cell index 0 and cell counter 0.
  - RUN: oWG=1. The cell counter counts 0..CELL_CLKS-1; a cell boundary is counter==CELL_CLKS-1. Cell index 0..15 advances at each boundary.
- Cell encoding for data bit d (MSB first), using prev_data = the previous data bit:
  - Even cell (clock) = ~(prev_data | d).
  - Odd cell (data) = d.
  - If the byte's mark flag is set, the clock cell of bit position 5 (cell index 10) is forced to 0.
  - prev_data updates after each data cell and carries across bytes. It resets to 0 only on reset, iSTART=0, or IDLE entry.
- Pulse generation:
  - A cell value of 1 drives oWDATA=1 for cell counter 0..PULSE_CLKS-1, then 0.
  - A cell value of 0 keeps oWDATA low.
  - The first cell begins the cycle after the SR load.
- Byte boundary (end of cell 15):
  - oBYTE_DONE pulses.
  - If HR is full: HR moves to SR with no gap cell, and oREADY rises the next cycle.
  - If HR is empty: SR loads 0x00 with mark=0 and oLOST pulses; RUN continues.
- Simultaneous iWR and byte-boundary transfer in the same cycle: the transfer happens first (the 0x00 filler if HR was empty). The written byte is then captured into HR; it is not lost.
- RUN continues until iSTART=0. There is no other exit.

Test Plan:
- Reset then iSTART=1, iWR 0x4E -> oREADY drops 1 cycle, rises after SR load; cell sequence 1001 0010 0101 0100 (0x9254); each 1-cell is an 8-cycle pulse at cell start; cells are 56 cycles apart.
- Two back-to-back 0x00 writes -> 0xAAAA twice with no gap cell; oBYTE_DONE pulses at cycles 896 and 1792 after the first cell start.
- Byte 0x00 followed by A1 with iMARK=1 -> A1 encodes as 0x4489. The same A1 with iMARK=0 encodes as 0x44A9.
- Single 0xFF write with no further iWR -> 0x5555, then oLOST pulse at the boundary and 0x00 cells (0x2AAA, since prev_data=1); oWG stays 1.
- iWR asserted in the exact cycle of the byte-boundary transfer while HR is empty -> filler 0x00 is sent, oLOST pulses, and the written byte is encoded next.
- iSTART deasserted mid-pulse at cell 7 -> oWDATA and oWG are 0 next cycle, oREADY=1. A subsequent iSTART plus write restarts with prev_data=0 (0x4E gives 0x9254 again). Asynchronous reset mid-byte gives the same result.
